// File: rtl/rx_mf_slicer.sv
// rx_mf_slicer: QPSK receive matched filter, symbol decimator and hard-decision
// slicer for one rail (I or Q). Uses the 24-tap RRC set of the transmit shaper.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   enable          sample strobe, one sample per cycle with enable=1
//   i_rx[7:0]       signed input sample S(8,7)
//   i_phase[1:0]    decimation phase select, sampled on enable edges
//   o_filt[7:0]     registered, saturated filter output S(8,7), one-enable latency
//   o_bit           hard decision (acc >= 0 -> 1)
//   o_valid         one-cycle pulse when o_bit is updated
// Optional (`define RX_ERRCNT_EN):
//   i_ref           reference bit compared against each decision
//   i_clr           synchronous clear of the error counter (wins over increment)
//   o_err_cnt[15:0] saturating decision-error counter

// One tap: full-precision signed product, sign-extended to the accumulator width.
module rx_mf_tap #(
  parameter int DW = 8,
  parameter int AW = 20,
  parameter logic [DW-1:0] COEF = '0
) (
  input  logic [DW-1:0] smp,
  output logic [AW-1:0] prod
);
  logic signed [2*DW-1:0] p;
  assign p    = $signed(smp) * $signed(COEF);
  assign prod = {{(AW-2*DW){p[2*DW-1]}}, p};
endmodule

module rx_mf_slicer #(
  parameter int NTAPS = 24,
  parameter int OS    = 4,
  parameter int DW    = 8,
  parameter int AW    = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [DW-1:0] i_rx,
  input  logic [1:0]    i_phase,
`ifdef RX_ERRCNT_EN
  input  logic          i_ref,
  input  logic          i_clr,
  output logic [15:0]   o_err_cnt,
`endif
  output logic [DW-1:0] o_filt,
  output logic          o_bit,
  output logic          o_valid
);
  // Coefficient table, tap 23 in the top byte down to tap 0 in the bottom byte.
  localparam logic [24*8-1:0] COEF_TBL =
    192'hFEFF0002_00FBF5F9_0A253E48_3E250AF9_F5FB0002_00FFFE00;
  localparam logic signed [AW-1:0] YMAX = AW'(127);
  localparam logic signed [AW-1:0] YMIN = -AW'(128);

  logic [NTAPS-1:0][DW-1:0] sbuf;   // sbuf[0] is the newest sample
  logic [NTAPS-1:0][AW-1:0] prod;
  logic signed [AW-1:0]     acc, y;
  logic [DW-1:0]            sat;
  logic [1:0]               phase_cnt;
  logic                     d, hit;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    rx_mf_tap #(.DW(DW), .AW(AW), .COEF(COEF_TBL[k*8 +: 8])) u_tap (
      .smp (sbuf[k]),
      .prod(prod[k])
    );
  end

  // |acc| <= 128*346, comfortably inside AW bits, so plain wrap-free summing.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) acc = acc + $signed(prod[k]);
  end

  assign y = acc >>> 7;
  always_comb begin
    sat = y[DW-1:0];
    if (y > YMAX)      sat = 8'h7F;
    else if (y < YMIN) sat = 8'h80;
  end

  assign d   = ~acc[AW-1];                        // zero slices to 1
  assign hit = enable && (phase_cnt == i_phase);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbuf      <= '0;
      phase_cnt <= '0;
      o_filt    <= '0;
      o_bit     <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= hit;
      if (enable) begin
        o_filt    <= sat;                         // from the pre-shift buffer
        sbuf      <= {sbuf[NTAPS-2:0], i_rx};
        phase_cnt <= phase_cnt + 2'd1;
        if (hit) o_bit <= d;
      end
    end
  end

`ifdef RX_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        o_err_cnt <= '0;
    else if (i_clr)                                 o_err_cnt <= '0;
    else if (hit && (d != i_ref) && ~&o_err_cnt)   o_err_cnt <= o_err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rx_mf_slicer.sv
module tb_rx_mf_slicer;
  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [7:0] i_rx = '0;
  logic [1:0] i_phase = '0;
  logic [7:0] o_filt;
  logic       o_bit, o_valid;
`ifdef RX_ERRCNT_EN
  logic        i_ref = 1'b0, i_clr = 1'b0;
  logic [15:0] o_err_cnt;
  int          e_err;
`endif

  int total = 0, bad = 0;
  int coef[24] = '{0, -2, -1, 0, 2, 0, -5, -11, -7, 10, 37, 62,
                   72, 62, 37, 10, -7, -11, -5, 0, 2, 0, -1, -2};
  logic [7:0] imp[25] = '{8'h00, 8'h02, 8'h01, 8'h00, 8'hFE, 8'h00, 8'h05, 8'h0B,
                          8'h07, 8'hF6, 8'hDB, 8'hC2, 8'hB8, 8'hC2, 8'hDB, 8'hF6,
                          8'h07, 8'h0B, 8'h05, 8'h00, 8'hFE, 8'h00, 8'h01, 8'h02, 8'h00};

  // reference state: sample history (newest first) and enable count mod 4
  int         hist[24];
  int         cnt;
  logic [7:0] e_filt;
  logic       e_bit, e_valid;

  rx_mf_slicer dut (
    .clk(clk), .rst(rst), .enable(enable), .i_rx(i_rx), .i_phase(i_phase),
`ifdef RX_ERRCNT_EN
    .i_ref(i_ref), .i_clr(i_clr), .o_err_cnt(o_err_cnt),
`endif
    .o_filt(o_filt), .o_bit(o_bit), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  function automatic int macc();
    int s = 0;
    for (int k = 0; k < 24; k++) s += hist[k] * coef[k];
    return s;
  endfunction

  // floor(a/128), then clamp to the 8-bit signed range
  function automatic logic [7:0] satf(input int a);
    int m, y;
    logic [31:0] yy;
    m = ((a % 128) + 128) % 128;
    y = (a - m) / 128;
    if (y > 127)  return 8'h7F;
    if (y < -128) return 8'h80;
    yy = y;
    return yy[7:0];
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 24; k++) hist[k] = 0;
    cnt = 0; e_filt = '0; e_bit = 1'b0; e_valid = 1'b0;
`ifdef RX_ERRCNT_EN
    e_err = 0;
`endif
  endtask

  task automatic model_edge();
    int a;
    if (rst) begin reset_model(); return; end
    a = macc();
    e_valid = 1'b0;
    if (enable) begin
      e_filt = satf(a);
      if (cnt == int'(i_phase)) begin e_bit = (a >= 0); e_valid = 1'b1; end
      for (int k = 23; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'($signed(i_rx));
      cnt = (cnt + 1) % 4;
    end
`ifdef RX_ERRCNT_EN
    if (i_clr) e_err = 0;
    else if (e_valid && (e_bit != i_ref) && e_err < 65535) e_err++;
`endif
  endtask

  task automatic chk(input string tag);
    total++;
    assert (o_filt === e_filt) else begin
      bad++; $error("FAIL %s filt got=%h exp=%h", tag, o_filt, e_filt);
    end
    total++;
    assert (o_bit === e_bit) else begin
      bad++; $error("FAIL %s bit got=%b exp=%b", tag, o_bit, e_bit);
    end
    total++;
    assert (o_valid === e_valid) else begin
      bad++; $error("FAIL %s valid got=%b exp=%b", tag, o_valid, e_valid);
    end
`ifdef RX_ERRCNT_EN
    total++;
    assert (o_err_cnt === 16'(e_err)) else begin
      bad++; $error("FAIL %s errcnt got=%0d exp=%0d", tag, o_err_cnt, e_err);
    end
`endif
  endtask

  task automatic step(input logic en, input logic [7:0] x, input string tag);
    enable = en; i_rx = x;
    @(posedge clk);
    model_edge();
    #1 chk(tag);
  endtask

  initial begin
    int pulses;
    reset_model();
    // reset state
    step(1'b1, 8'h55, "rst_hold");
    step(1'b0, 8'h00, "rst_hold2");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 8'h00, "zeros");

    // impulse response, plus the explicit table
    step(1'b1, 8'h80, "imp_in");
    for (int k = 0; k < 25; k++) begin
      step(1'b1, 8'h00, "imp");
      total++;
      assert (o_filt === imp[k]) else begin
        bad++; $error("FAIL imp_tbl[%0d] got=%h exp=%h", k, o_filt, imp[k]);
      end
    end

    // saturation both ways
    for (int i = 0; i < 30; i++) step(1'b1, 8'h7F, "sat_pos");
    total++;
    assert (o_filt === 8'h7F && o_bit === 1'b1) else begin
      bad++; $error("FAIL sat_pos got=%h/%b exp=7f/1", o_filt, o_bit);
    end
    for (int i = 0; i < 30; i++) step(1'b1, 8'h80, "sat_neg");
    total++;
    assert (o_filt === 8'h80 && o_bit === 1'b0) else begin
      bad++; $error("FAIL sat_neg got=%h/%b exp=80/0", o_filt, o_bit);
    end

    // asynchronous reset mid-stream, observed before any clock edge
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), "pre_rst");
    #2 rst = 1'b1;
    #1 reset_model();
    chk("async_rst");
    step(1'b1, 8'h7F, "in_rst");
    rst = 1'b0;

    // decimation: phase 2, enable every 3rd cycle, 40 enables -> 10 pulses
    i_phase = 2'd2;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), "dec_en");  pulses += int'(o_valid);
      step(1'b0, 8'($urandom), "dec_gap"); pulses += int'(o_valid);
      step(1'b0, 8'($urandom), "dec_gap"); pulses += int'(o_valid);
    end
    total++;
    assert (pulses == 10) else begin
      bad++; $error("FAIL dec_pulses got=%0d exp=10", pulses);
    end

    // randomized traffic with occasional phase switches
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) i_phase = 2'($urandom);
`ifdef RX_ERRCNT_EN
      i_ref = 1'($urandom);
      i_clr = ($urandom_range(0, 39) == 0);
`endif
      step($urandom_range(0, 9) < 7, (i % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom), "rand");
    end

`ifdef RX_ERRCNT_EN
    // forced mismatches, then clear coinciding with a mismatch
    i_clr = 1'b1; step(1'b0, 8'h00, "clr");
    i_clr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      i_ref = (cnt == int'(i_phase)) ? ~(macc() >= 0) : 1'b0;
      step(1'b1, 8'($urandom), "mis");
    end
    total++;
    assert (o_err_cnt === 16'd10) else begin
      bad++; $error("FAIL err_mis got=%0d exp=10", o_err_cnt);
    end
    while (cnt != int'(i_phase)) step(1'b1, 8'($urandom), "align");
    i_ref = ~(macc() >= 0); i_clr = 1'b1;
    step(1'b1, 8'($urandom), "clr_vs_inc");
    i_clr = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
